// File: rtl/digit_stream_pkg.sv
// Shared definitions for the decimal digit streamer: FSM state codes and
// constant helpers that size the BCD register and the hold/gap timer.
package digit_stream_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_CONVERT = 3'd1;
    localparam state_t ST_HOLD    = 3'd2;
    localparam state_t ST_GAP     = 3'd3;
    localparam state_t ST_FINISH  = 3'd4;

    // ceil(num_w * log10(2)) + 1 decimal digits hold any num_w-bit value
    function automatic int bcd_digits(input int num_w);
        return (num_w * 32'sd30103 + 32'sd99999) / 32'sd100000 + 32'sd1;
    endfunction

    function automatic int timer_width(input int hold_cycles, input int gap_cycles);
        int longest;
        longest = (hold_cycles > gap_cycles) ? hold_cycles : gap_cycles;
        return $clog2(longest + 32'sd1);
    endfunction

endpackage

// File: rtl/digit_stream_sender_bin2bcd.sv
// Sequential double-dabble converter: one input bit per cycle, NUM_W cycles
// after load the BCD result is presented and held with bcd_valid high.
module bin2bcd_seq #(
    parameter int NUM_W = 32,
    parameter int BCD_N = 11
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [NUM_W-1:0]   bin,
    output logic [BCD_N*4-1:0] bcd,
    output logic               bcd_valid
);
    localparam int CNT_W = $clog2(NUM_W + 1);

    logic [NUM_W-1:0]   shift_r;
    logic [CNT_W-1:0]   count_r;
    logic [BCD_N*4-1:0] adj_s;

    // Add-3 correction on every digit that would reach ten after the next shift
    always_comb begin
        adj_s = bcd;
        for (int i = 0; i < BCD_N; i++) begin
            if (bcd[i*4 +: 4] >= 4'd5) begin
                adj_s[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
            end else begin
                adj_s[i*4 +: 4] = bcd[i*4 +: 4];
            end
        end
    end

    // Shift one binary bit into the corrected BCD register per cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_r   <= '0;
            count_r   <= '0;
            bcd       <= '0;
            bcd_valid <= 1'b0;
        end else if (load) begin
            shift_r   <= bin;
            count_r   <= CNT_W'(NUM_W);
            bcd       <= '0;
            bcd_valid <= 1'b0;
        end else if (count_r != '0) begin
            bcd       <= {adj_s[BCD_N*4-2:0], shift_r[NUM_W-1]};
            shift_r   <= shift_r << 1;
            count_r   <= count_r - 1'b1;
            bcd_valid <= (count_r == CNT_W'(1));
        end
    end

endmodule

// File: rtl/digit_stream_sender.sv
// Streams a binary value as decimal digits, most significant first, as timed
// symbols with a valid strobe; reports overflow beyond DIGITS digits.
module digit_stream_sender
    import digit_stream_pkg::*;
#(
    parameter int NUM_W       = 32,
    parameter int DIGITS      = 6,
    parameter int SYM_W       = 4,
    parameter int HOLD_CYCLES = 1200000,
    parameter int GAP_CYCLES  = 120000
) (
    input  logic             hwclk,
    input  logic             rst,
    input  logic [NUM_W-1:0] num,
    input  logic             start,
    input  logic             suppress_lz,
    output logic             busy,
    output logic [SYM_W-1:0] sym,
    output logic             sym_valid,
    output logic             done,
    output logic             overflow
);
    localparam int BCD_REQ = bcd_digits(NUM_W);
    localparam int BCD_N   = (BCD_REQ > DIGITS) ? BCD_REQ : DIGITS;
    localparam int CNT_W   = timer_width(HOLD_CYCLES, GAP_CYCLES);
    localparam int PTR_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    state_t              state_r;
    logic [PTR_W-1:0]    ptr_r;
    logic [CNT_W-1:0]    timer_r;
    logic [DIGITS*4-1:0] digits_r;
    logic                lz_r;
    logic                ovf_pend_r;

    logic                accept_s;
    logic [BCD_N*4-1:0]  bcd_s;
    logic                bcd_valid_s;
    logic                ovf_s;
    logic [PTR_W-1:0]    lead_ptr_s;
    logic [PTR_W-1:0]    start_ptr_s;
    logic [PTR_W-1:0]    next_ptr_s;

    // The done cycle doubles as IDLE so a held start re-arms without a gap
    assign accept_s   = start && ((state_r == ST_IDLE) || (state_r == ST_FINISH));
    assign next_ptr_s = ptr_r - 1'b1;

    bin2bcd_seq #(
        .NUM_W (NUM_W),
        .BCD_N (BCD_N)
    ) u_bin2bcd (
        .clk       (hwclk),
        .rst       (rst),
        .load      (accept_s),
        .bin       (num),
        .bcd       (bcd_s),
        .bcd_valid (bcd_valid_s)
    );

    // Overflow detect and first-digit selection from the finished conversion
    always_comb begin
        ovf_s = 1'b0;
        for (int i = DIGITS; i < BCD_N; i++) begin
            ovf_s = ovf_s | (bcd_s[i*4 +: 4] != 4'd0);
        end
        lead_ptr_s = '0;
        for (int i = 1; i < DIGITS; i++) begin
            lead_ptr_s = (bcd_s[i*4 +: 4] != 4'd0) ? PTR_W'(i) : lead_ptr_s;
        end
        if (lz_r) begin
            start_ptr_s = lead_ptr_s;
        end else begin
            start_ptr_s = PTR_W'(DIGITS - 1);
        end
    end

    // Transfer FSM with hold/gap timing; all outputs registered
    always_ff @(posedge hwclk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            ptr_r      <= '0;
            timer_r    <= '0;
            digits_r   <= '0;
            lz_r       <= 1'b0;
            ovf_pend_r <= 1'b0;
            busy       <= 1'b0;
            sym        <= '0;
            sym_valid  <= 1'b0;
            done       <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_r)
                ST_IDLE, ST_FINISH: begin
                    if (accept_s) begin
                        state_r  <= ST_CONVERT;
                        lz_r     <= suppress_lz;
                        overflow <= 1'b0;
                        busy     <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                        busy    <= 1'b0;
                    end
                end
                ST_CONVERT: begin
                    if (bcd_valid_s) begin
                        digits_r   <= bcd_s[DIGITS*4-1:0];
                        ovf_pend_r <= ovf_s;
                        ptr_r      <= start_ptr_s;
                        timer_r    <= CNT_W'(HOLD_CYCLES - 1);
                        sym        <= SYM_W'(bcd_s[{start_ptr_s, 2'b00} +: 4]);
                        sym_valid  <= 1'b1;
                        state_r    <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (timer_r == '0) begin
                        timer_r   <= CNT_W'(GAP_CYCLES - 1);
                        sym       <= '0;
                        sym_valid <= 1'b0;
                        state_r   <= ST_GAP;
                    end else begin
                        timer_r <= timer_r - 1'b1;
                    end
                end
                ST_GAP: begin
                    if (timer_r != '0) begin
                        timer_r <= timer_r - 1'b1;
                    end else if (ptr_r == '0) begin
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        overflow <= ovf_pend_r;
                        state_r  <= ST_FINISH;
                    end else begin
                        ptr_r     <= next_ptr_s;
                        timer_r   <= CNT_W'(HOLD_CYCLES - 1);
                        sym       <= SYM_W'(digits_r[{next_ptr_s, 2'b00} +: 4]);
                        sym_valid <= 1'b1;
                        state_r   <= ST_HOLD;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    busy      <= 1'b0;
                    sym       <= '0;
                    sym_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_digit_stream_sender.sv
// Bench for digit_stream_sender: DIGITS=6 and DIGITS=10 instances share stimulus,
// each checked every cycle against an arithmetic model of the expected waveform.
module tb_digit_stream_sender;
    localparam int NUM_W = 32;
    localparam int H     = 4;
    localparam int G     = 2;

    logic        hwclk = 1'b0;
    logic        rst, start, suppress_lz;
    logic [31:0] num;
    logic        busy [2];
    logic        sym_valid [2];
    logic        done [2];
    logic        overflow [2];
    logic [3:0]  sym [2];

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    logic rst_q, start_q, lz_q;
    logic [31:0] num_q;
    int   obs0[$];
    int   obs1[$];
    int   done_off [2];
    int   first_off [2];
    logic ovf_at_done [2];

    always #5 hwclk = ~hwclk;

    always @(posedge hwclk) begin
        cyc     <= cyc + 1;
        rst_q   <= rst;
        start_q <= start;
        lz_q    <= suppress_lz;
        num_q   <= num;
    end

    function automatic longint pow10(input int n);
        longint p = 1;
        for (int i = 0; i < n; i++) p = p * 10;
        return p;
    endfunction

    function automatic string seq_str(input int q[$]);
        string s = "";
        foreach (q[i]) s = {s, $sformatf("%0d", q[i])};
        return s;
    endfunction

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h want %0h", n, cyc, act, exp);
        end
    endtask

    task automatic chk_str(input string n, input string act, input string exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got '%s' want '%s'", n, act, exp);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : inst
        localparam int D = (g == 0) ? 6 : 10;

        digit_stream_sender #(
            .NUM_W(NUM_W), .DIGITS(D), .SYM_W(4), .HOLD_CYCLES(H), .GAP_CYCLES(G)
        ) dut (
            .hwclk(hwclk), .rst(rst), .num(num), .start(start), .suppress_lz(suppress_lz),
            .busy(busy[g]), .sym(sym[g]), .sym_valid(sym_valid[g]),
            .done(done[g]), .overflow(overflow[g])
        );

        bit run = 1'b0;
        bit ovf_val = 1'b0;
        bit ovf_m = 1'b0;
        bit prev_v = 1'b0;
        int t = 0;
        int end_t = 0;
        int k = 0;
        int e0 = 0;
        int digs [10];

        // Model advance on inputs sampled at the last edge, then compare
        always @(negedge hwclk) begin : model
            longint v;
            bit e_busy, e_valid, e_done;
            int e_sym, u;
            if (rst_q === 1'b1) begin
                run = 1'b0;
                ovf_m = 1'b0;
            end else if ((!run || t == end_t) && start_q === 1'b1) begin
                run = 1'b1;
                t = 0;
                e0 = cyc;
                ovf_m = 1'b0;
                ovf_val = (longint'(num_q) >= pow10(D));
                v = longint'(num_q) % pow10(D);
                k = D;
                if (lz_q) begin
                    k = 1;
                    for (int i = 1; i < D; i++) if (v >= pow10(i)) k = i + 1;
                end
                for (int j = 0; j < k; j++) digs[j] = int'((v / pow10(k - 1 - j)) % 10);
                end_t = NUM_W + 1 + k * (H + G);
                if (g == 0) obs0.delete(); else obs1.delete();
            end else if (run) begin
                t++;
                if (t > end_t) run = 1'b0;
            end
            if (run && t == end_t) ovf_m = ovf_val;

            e_busy  = run && (t < end_t);
            e_done  = run && (t == end_t);
            e_valid = 1'b0;
            e_sym   = 0;
            if (run && t > NUM_W && t < end_t) begin
                u = t - NUM_W - 1;
                if (u % (H + G) < H) begin
                    e_valid = 1'b1;
                    e_sym   = digs[u / (H + G)];
                end
            end
            chk($sformatf("busy%0d", D), 32'(busy[g]), 32'(e_busy));
            chk($sformatf("done%0d", D), 32'(done[g]), 32'(e_done));
            chk($sformatf("sym_valid%0d", D), 32'(sym_valid[g]), 32'(e_valid));
            chk($sformatf("sym%0d", D), 32'(sym[g]), 32'(e_sym));
            chk($sformatf("overflow%0d", D), 32'(overflow[g]), 32'(ovf_m));

            if (sym_valid[g] === 1'b1 && !prev_v) begin
                if (g == 0) begin
                    if (obs0.size() == 0) first_off[g] = cyc - e0;
                    obs0.push_back(int'(sym[g]));
                end else begin
                    if (obs1.size() == 0) first_off[g] = cyc - e0;
                    obs1.push_back(int'(sym[g]));
                end
            end
            prev_v = (sym_valid[g] === 1'b1);
            if (done[g] === 1'b1) begin
                done_off[g]    = cyc - e0;
                ovf_at_done[g] = overflow[g];
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        do begin
            @(negedge hwclk);
            n++;
        end while ((busy[0] || busy[1] || done[0] || done[1]) && n < 400);
        checks++;
        if (n >= 400) begin
            errors++;
            $display("FAIL idle_timeout: waited %0d cycles, required under 400", n);
        end
    endtask

    task automatic start_pulse(input logic [31:0] n, input logic lz);
        @(negedge hwclk);
        num = n;
        suppress_lz = lz;
        start = 1'b1;
        @(negedge hwclk);
        start = 1'b0;
    endtask

    task automatic send(input logic [31:0] n, input logic lz);
        start_pulse(n, lz);
        wait_idle();
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        suppress_lz = 1'b0;
        num = '0;
        repeat (3) @(negedge hwclk);
        for (int g = 0; g < 2; g++) begin
            chk("reset_busy", 32'(busy[g]), 32'd0);
            chk("reset_sym", 32'(sym[g]), 32'd0);
            chk("reset_valid", 32'(sym_valid[g]), 32'd0);
            chk("reset_done", 32'(done[g]), 32'd0);
            chk("reset_ovf", 32'(overflow[g]), 32'd0);
        end
        rst = 1'b0;

        send(32'd1234, 1'b0);
        chk_str("seq6_1234", seq_str(obs0), "001234");
        chk_str("seq10_1234", seq_str(obs1), "0000001234");
        chk("first_valid6", first_off[0], 32'd33);
        chk("done_at6", done_off[0], 32'd69);
        chk("done_at10", done_off[1], 32'd93);
        chk("ovf6_1234", 32'(ovf_at_done[0]), 32'd0);

        send(32'd1234, 1'b1);
        chk_str("seq6_1234_lz", seq_str(obs0), "1234");
        chk("done_at6_lz", done_off[0], 32'd57);

        send(32'd0, 1'b1);
        chk_str("seq6_zero_lz", seq_str(obs0), "0");
        chk("done_at6_zero", done_off[0], 32'd39);

        send(32'd1234567, 1'b0);
        chk_str("seq6_big", seq_str(obs0), "234567");
        chk_str("seq10_big", seq_str(obs1), "0001234567");
        chk("ovf6_big", 32'(ovf_at_done[0]), 32'd1);
        chk("ovf6_held", 32'(overflow[0]), 32'd1);
        chk("ovf10_big", 32'(ovf_at_done[1]), 32'd0);

        send(32'hFFFF_FFFF, 1'b0);
        chk_str("seq10_max", seq_str(obs1), "4294967295");
        chk("ovf10_max", 32'(ovf_at_done[1]), 32'd0);
        chk("ovf6_max", 32'(ovf_at_done[0]), 32'd1);

        // Second start during the first HOLD must be ignored
        start_pulse(32'd1234, 1'b0);
        repeat (36) @(negedge hwclk);
        start_pulse(32'd999, 1'b1);
        wait_idle();
        chk_str("seq6_ignore", seq_str(obs0), "001234");

        // Start held high: re-arms on the edge that ends the done cycle
        @(negedge hwclk);
        num = 32'd42;
        suppress_lz = 1'b1;
        start = 1'b1;
        for (int i = 0; i < 200 && done[0] !== 1'b1; i++) @(negedge hwclk);
        chk("held_done_seen", 32'(done[0]), 32'd1);
        @(negedge hwclk);
        chk("held_rearm_busy", 32'(busy[0]), 32'd1);
        start = 1'b0;
        wait_idle();
        chk_str("seq6_held", seq_str(obs0), "42");

        // Reset during the third digit's HOLD aborts the transfer
        start_pulse(32'd1234, 1'b0);
        repeat (46) @(negedge hwclk);
        rst = 1'b1;
        @(negedge hwclk);
        rst = 1'b0;
        for (int g = 0; g < 2; g++) begin
            chk("abort_busy", 32'(busy[g]), 32'd0);
            chk("abort_valid", 32'(sym_valid[g]), 32'd0);
            chk("abort_sym", 32'(sym[g]), 32'd0);
            chk("abort_done", 32'(done[g]), 32'd0);
        end
        repeat (80) @(negedge hwclk);
        send(32'd1234, 1'b0);
        chk_str("seq6_after_abort", seq_str(obs0), "001234");

        for (int r = 0; r < 12; r++) begin
            logic [31:0] n;
            case ($urandom_range(0, 3))
                0: n = $urandom_range(0, 9);
                1: n = $urandom_range(0, 99999);
                2: n = $urandom;
                default: n = $urandom_range(999000, 1001000);
            endcase
            send(n, 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 3)) @(negedge hwclk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
